// File: rtl/vx_span_scoreboard.sv
// Purpose : per-slice register hazard tracker with counting entries, rd/rs2 register spans and NUM_WB writeback ports.
// Latency : 1 cycle from issue fire to out_valid; counters and busy_count reflect a fire/writeback one cycle later.
// Backpressure: in_ready drops while the output stage is full and not draining, or on any source/destination hazard.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   in_*            issue request (warp id, rd span, rs1, rs2 span, rs3, payload), valid/ready
//   out_*           1-entry registered output stage, valid/ready
//   wb_*            NUM_WB writeback ports; only eop packets retire an outstanding write
//   busy_count      number of nonzero counters (registered)
//   perf_stalls     wrapping count of cycles with in_valid & ~in_ready
//   err_underflow   sticky: eop writeback retired more writes than were outstanding
//   err_timeout     sticky: a continuous stall run reached TIMEOUT
module vx_span_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64,
  parameter int MAX_SPAN  = 4,
  parameter int CNT_W     = 2,
  parameter int NUM_WB    = 2,
  parameter int WAW_STALL = 0,
  parameter int DATAW     = 64,
  parameter int TIMEOUT   = 4096,
  parameter int PERF_W    = 44,
  localparam int WIDW     = $clog2(NUM_WARPS),
  localparam int RW       = $clog2(NUM_REGS),
  localparam int SPW      = $clog2(MAX_SPAN),
  localparam int BUSYW    = $clog2(NUM_WARPS * NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDW-1:0]          in_wid,
  input  logic                     in_wb,
  input  logic [RW-1:0]            in_rd,
  input  logic [SPW-1:0]           in_rd_span,
  input  logic [RW-1:0]            in_rs1,
  input  logic [RW-1:0]            in_rs2,
  input  logic [SPW-1:0]           in_rs2_span,
  input  logic [RW-1:0]            in_rs3,
  input  logic [DATAW-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATAW-1:0]         out_data,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB-1:0]        wb_eop,
  input  logic [NUM_WB*WIDW-1:0]   wb_wid,
  input  logic [NUM_WB*RW-1:0]     wb_rd,
  output logic [BUSYW-1:0]         busy_count,
  output logic [PERF_W-1:0]        perf_stalls,
  output logic                     err_underflow,
  output logic                     err_timeout
);

  localparam int RUNW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Outstanding-write counters, one bank per warp.
  logic [CNT_W-1:0] cnt_q [NUM_WARPS][NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_WARPS][NUM_REGS];

  logic             stg_ready;
  logic             src_hazard;
  logic             dst_sat;
  logic             dst_nz;
  logic             dst_hazard;
  logic             hazard;
  logic             fire;
  logic             stall;
  logic [CNT_W-1:0] rd_cnt;
  logic [NUM_REGS-1:0] rd_hit;
  logic             underflow_d;
  logic [BUSYW-1:0] busy_d;
  logic [RUNW-1:0]  run_q;
  logic [RUNW-1:0]  run_d;

  // Register k of a span starting at base; spans wrap past the top register.
  function automatic logic [RW-1:0] span_reg(input logic [RW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REGS;
    return RW'(s);
  endfunction

  // Hazard detection from registered counters only; a writeback landing this
  // cycle does not unblock the request until the next cycle.
  always_comb begin
    src_hazard = 1'b0;
    dst_sat    = 1'b0;
    dst_nz     = 1'b0;
    rd_cnt     = '0;
    if (cnt_q[in_wid][in_rs1] != '0) src_hazard = 1'b1;
    if (cnt_q[in_wid][in_rs3] != '0) src_hazard = 1'b1;
    for (int k = 0; k < MAX_SPAN; k++) begin
      if (k <= int'(in_rs2_span)) begin
        if (cnt_q[in_wid][span_reg(in_rs2, k)] != '0) src_hazard = 1'b1;
      end
      if (k <= int'(in_rd_span)) begin
        rd_cnt = cnt_q[in_wid][span_reg(in_rd, k)];
        if (rd_cnt == CNT_MAX) dst_sat = 1'b1;
        if (rd_cnt != '0)      dst_nz  = 1'b1;
      end
    end
  end

  // A saturated counter must stall a new write, otherwise it would wrap.
  assign dst_hazard = in_wb & (dst_sat | ((WAW_STALL != 0) & dst_nz));
  assign hazard     = src_hazard | dst_hazard;
  assign stg_ready  = ~out_valid | out_ready;
  assign in_ready   = stg_ready & ~hazard;
  assign fire       = in_valid & in_ready;
  assign stall      = in_valid & ~in_ready;

  // Membership of each register in the (possibly wrapping) rd span.
  always_comb begin
    int off;
    off    = 0;
    rd_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      off       = (r - int'(in_rd) + NUM_REGS) % NUM_REGS;
      rd_hit[r] = (off <= int'(in_rd_span));
    end
  end

  // Counter next state: issue increments and eop writebacks decrement in the
  // same cycle net out; retiring more than is outstanding clamps at zero.
  always_comb begin
    int sum;
    int dec;
    int busy;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    busy        = 0;
    sum         = 0;
    dec         = 0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        dec = 0;
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_valid[p] && wb_eop[p] &&
              wb_wid[p*WIDW +: WIDW] == WIDW'(w) &&
              wb_rd[p*RW +: RW] == RW'(r)) begin
            dec = dec + 1;
          end
        end
        sum = int'(cnt_q[w][r]);
        if (fire && in_wb && in_wid == WIDW'(w) && rd_hit[r]) sum = sum + 1;
        if (dec > sum) begin
          cnt_d[w][r] = '0;
          underflow_d = 1'b1;
        end else begin
          cnt_d[w][r] = CNT_W'(sum - dec);
        end
        if (cnt_d[w][r] != '0) busy = busy + 1;
      end
    end
    busy_d = BUSYW'(busy);
  end

  // Stall run length, held at TIMEOUT once reached.
  always_comb begin
    run_d = '0;
    if (stall) begin
      if (run_q == RUNW'(TIMEOUT)) run_d = run_q;
      else                         run_d = run_q + RUNW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q         <= '{default: '0};
      out_valid     <= 1'b0;
      busy_count    <= '0;
      perf_stalls   <= '0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
      run_q         <= '0;
    end else begin
      cnt_q      <= cnt_d;
      busy_count <= busy_d;
      run_q      <= run_d;
      if (fire)           out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (stall)       perf_stalls   <= perf_stalls + PERF_W'(1);
      if (underflow_d) err_underflow <= 1'b1;
      if (run_d == RUNW'(TIMEOUT)) err_timeout <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed while out_valid is set.
  always_ff @(posedge clk) begin
    if (fire) out_data <= in_data;
  end

endmodule

// File: tb/tb_vx_span_scoreboard.sv
// Purpose : randomized + directed bench for vx_span_scoreboard with a queue scoreboard and reference model.
// Latency : expects out_valid one cycle after each fire.
// Backpressure: out_ready is toggled to exercise a held output stage.
module tb_vx_span_scoreboard;

  localparam int NW  = 4;
  localparam int NR  = 64;
  localparam int CW  = 2;
  localparam int NB  = 2;
  localparam int DW  = 64;
  localparam int TO  = 16;
  localparam int PW  = 44;
  localparam int WAW = 0;
  localparam int WW  = 2;
  localparam int RB  = 6;
  localparam int SW  = 2;
  localparam int BW  = 9;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WW-1:0]   in_wid;
  logic            in_wb;
  logic [RB-1:0]   in_rd;
  logic [SW-1:0]   in_rd_span;
  logic [RB-1:0]   in_rs1;
  logic [RB-1:0]   in_rs2;
  logic [SW-1:0]   in_rs2_span;
  logic [RB-1:0]   in_rs3;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [NB-1:0]   wb_valid;
  logic [NB-1:0]   wb_eop;
  logic [NB*WW-1:0] wb_wid;
  logic [NB*RB-1:0] wb_rd;
  logic [BW-1:0]   busy_count;
  logic [PW-1:0]   perf_stalls;
  logic            err_underflow;
  logic            err_timeout;

  vx_span_scoreboard #(
    .NUM_WARPS(NW), .NUM_REGS(NR), .MAX_SPAN(4), .CNT_W(CW), .NUM_WB(NB),
    .WAW_STALL(WAW), .DATAW(DW), .TIMEOUT(TO), .PERF_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb),
    .in_rd(in_rd), .in_rd_span(in_rd_span), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs2_span(in_rs2_span), .in_rs3(in_rs3), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wb_valid(wb_valid), .wb_eop(wb_eop), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .busy_count(busy_count), .perf_stalls(perf_stalls),
    .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          cnt_m [NW][NR];
  bit          ov_m;
  bit          uf_m;
  bit          to_m;
  int          run_m;
  int          busy_m;
  longint      perf_m;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (cnt_m[w, r]) cnt_m[w][r] = 0;
    ov_m = 0; uf_m = 0; to_m = 0; run_m = 0; busy_m = 0; perf_m = 0;
    exp_q.delete();
  endtask

  // Hazard rule applied to the request currently on the inputs.
  function automatic bit model_hazard();
    bit h;
    int c;
    h = 0;
    if (cnt_m[in_wid][in_rs1] != 0 || cnt_m[in_wid][in_rs3] != 0) h = 1;
    for (int k = 0; k <= int'(in_rs2_span); k++)
      if (cnt_m[in_wid][(int'(in_rs2) + k) % NR] != 0) h = 1;
    if (in_wb) begin
      for (int k = 0; k <= int'(in_rd_span); k++) begin
        c = cnt_m[in_wid][(int'(in_rd) + k) % NR];
        if (c == (1 << CW) - 1) h = 1;
        if (WAW != 0 && c != 0) h = 1;
      end
    end
    return h;
  endfunction

  // One clock cycle: compare DUT against the model, advance the model, cross the edge.
  task automatic step();
    bit rdy_m, fire_m, stall_m;
    int nc [NW][NR];
    #2;
    rdy_m = (!ov_m || out_ready) && !model_hazard();
    chk("in_ready", in_ready, rdy_m);
    chk("out_valid", out_valid, ov_m);
    chk("busy_count", busy_count, busy_m);
    chk("err_underflow", err_underflow, uf_m);
    chk("err_timeout", err_timeout, to_m);
    chk("perf_stalls", perf_stalls, perf_m);
    fire_m  = in_valid && rdy_m;
    stall_m = in_valid && !rdy_m;
    if (!reset) begin
      model_reset();
    end else begin
      nc = cnt_m;
      if (fire_m && in_wb)
        for (int k = 0; k <= int'(in_rd_span); k++) nc[in_wid][(int'(in_rd) + k) % NR] += 1;
      for (int p = 0; p < NB; p++)
        if (wb_valid[p] && wb_eop[p]) nc[wb_wid[p*WW +: WW]][wb_rd[p*RB +: RB]] -= 1;
      busy_m = 0;
      foreach (nc[w, r]) begin
        if (nc[w][r] < 0) begin nc[w][r] = 0; uf_m = 1; end
        if (nc[w][r] != 0) busy_m++;
      end
      cnt_m = nc;
      if (fire_m) begin
        exp_q.push_back(in_data);
        ov_m = 1;
      end else if (out_ready) begin
        ov_m = 0;
      end
      if (stall_m) begin
        perf_m++;
        run_m = (run_m < TO) ? run_m + 1 : TO;
        if (run_m == TO) to_m = 1;
      end else begin
        run_m = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expected payload on every output transfer.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_data actual=%0h expected=none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
  end

  task automatic idle();
    in_valid = 0; in_wb = 0; in_wid = '0; in_rd = '0; in_rd_span = '0;
    in_rs1 = 6'd40; in_rs2 = 6'd40; in_rs2_span = '0; in_rs3 = 6'd40;
    wb_valid = '0; wb_eop = '0; wb_wid = '0; wb_rd = '0;
  endtask

  task automatic issue(input int w, input bit wb, input int rd, input int rds,
                       input int rs1, input int rs2, input int rs2s, input int rs3,
                       input logic [DW-1:0] d);
    in_valid = 1; in_wid = WW'(w); in_wb = wb; in_rd = RB'(rd); in_rd_span = SW'(rds);
    in_rs1 = RB'(rs1); in_rs2 = RB'(rs2); in_rs2_span = SW'(rs2s); in_rs3 = RB'(rs3);
    in_data = d;
  endtask

  task automatic set_wb(input int p, input bit v, input bit e, input int w, input int r);
    wb_valid[p] = v;
    wb_eop[p]   = e;
    wb_wid[p*WW +: WW] = WW'(w);
    wb_rd[p*RB +: RB]  = RB'(r);
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 11));
    return (r < 8) ? r : r + 52;
  endfunction

  initial begin
    logic [PW-1:0] p0;
    int w, r;
    idle();
    in_data = '0;
    out_ready = 1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_count, 0);
    chk("rst_perf", perf_stalls, 0);
    chk("rst_underflow", err_underflow, 0);
    chk("rst_timeout", err_timeout, 0);
    reset = 1;
    step();

    // 1: RAW on rs1 cleared by eop writeback on port 1
    issue(0, 1, 5, 0, 40, 40, 0, 40, 64'h1111);
    step();
    idle();
    chk("t1_out_valid", out_valid, 1);
    issue(0, 0, 0, 0, 5, 40, 0, 40, 64'h2222);
    #1 chk("t1_raw_stall", in_ready, 0);
    step();
    set_wb(1, 1, 1, 0, 5);
    step();
    wb_valid = '0; wb_eop = '0;
    #1 chk("t1_ready_after_wb", in_ready, 1);
    step();
    idle();
    step();

    // 2: wrapping rd span, rs2 stall, dual-port writeback
    issue(1, 1, 62, 3, 40, 40, 0, 40, 64'h3333);
    step();
    chk("t2_busy4", busy_count, 4);
    issue(1, 0, 0, 0, 40, 0, 0, 40, 64'h4444);
    #1 chk("t2_rs2_wrap_stall", in_ready, 0);
    set_wb(0, 1, 1, 1, 63);
    set_wb(1, 1, 1, 1, 0);
    step();
    wb_valid = '0; wb_eop = '0;
    chk("t2_busy2", busy_count, 2);
    #1 chk("t2_rs2_after_wb", in_ready, 1);
    step();
    issue(1, 0, 0, 0, 40, 62, 0, 40, 64'h5555);
    #1 chk("t2_rs2_62_stall", in_ready, 0);
    set_wb(0, 1, 1, 1, 62);
    set_wb(1, 1, 1, 1, 1);
    step();
    idle();
    step();

    // 3: counter saturation on rd=7
    issue(2, 1, 7, 0, 40, 40, 0, 40, 64'h7000);
    repeat (3) step();
    #1 chk("t3_sat_stall", in_ready, 0);
    step();
    set_wb(0, 1, 1, 2, 7);
    step();
    wb_valid = '0; wb_eop = '0;
    #1 chk("t3_fire_after_eop", in_ready, 1);
    step();
    #1 chk("t3_still_sat", in_ready, 0);
    idle();
    set_wb(0, 1, 1, 2, 7);
    repeat (3) step();
    idle();
    step();
    chk("t3_drained", busy_count, 0);

    // 4: same-cycle issue/writeback, then duplicate eop underflow
    issue(3, 1, 9, 0, 40, 40, 0, 40, 64'h9001);
    step();
    issue(3, 1, 9, 0, 40, 40, 0, 40, 64'h9002);
    set_wb(0, 1, 1, 3, 9);
    #1 chk("t4_issue_with_wb", in_ready, 1);
    step();
    idle();
    chk("t4_cnt_net", busy_count, 1);
    set_wb(0, 1, 1, 3, 9);
    set_wb(1, 1, 1, 3, 9);
    step();
    idle();
    chk("t4_underflow", err_underflow, 1);
    chk("t4_cnt_zero", busy_count, 0);

    // 5: output backpressure, then full-throughput stream
    out_ready = 0;
    issue(0, 0, 0, 0, 40, 40, 0, 40, 64'hA5A5);
    step();
    issue(0, 0, 0, 0, 40, 40, 0, 40, 64'hB6B6);
    #1 chk("t5_backpressure", in_ready, 0);
    p0 = perf_stalls;
    repeat (3) step();
    chk("t5_hold", out_data, 64'hA5A5);
    chk("t5_perf", perf_stalls - p0, 3);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      issue(i % NW, 0, 0, 0, 40, 40, 0, 40, 64'hC000 + 64'(i));
      #1 chk("t5_stream", in_ready, 1);
      step();
    end
    idle();
    repeat (2) step();

    // 6: timeout then reset mid-stall
    issue(0, 1, 20, 0, 40, 40, 0, 40, 64'hD000);
    step();
    out_ready = 0;
    issue(0, 0, 0, 0, 40, 40, 0, 40, 64'hD001);
    repeat (10) step();
    chk("t6_no_timeout_yet", err_timeout, 0);
    repeat (8) step();
    chk("t6_timeout", err_timeout, 1);
    reset = 0;
    step();
    chk("t6_rst_busy", busy_count, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_underflow", err_underflow, 0);
    chk("t6_rst_timeout", err_timeout, 0);
    reset = 1;
    out_ready = 1;
    issue(0, 0, 0, 0, 20, 40, 0, 40, 64'hD002);
    #1 chk("t6_cnt_cleared", in_ready, 1);
    step();
    idle();
    set_wb(0, 1, 1, 0, 20);
    step();
    idle();
    chk("t6_post_reset_underflow", err_underflow, 1);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        issue(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), pick_reg(),
              int'($urandom_range(0, 3)), pick_reg(), pick_reg(),
              int'($urandom_range(0, 3)), pick_reg(), {$urandom, $urandom});
      else
        in_valid = 0;
      wb_valid = '0;
      wb_eop   = '0;
      for (int p = 0; p < NB; p++) begin
        w = int'($urandom_range(0, 3));
        r = pick_reg();
        if ((cnt_m[w][r] > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0)
          set_wb(p, 1, ($urandom_range(0, 7) != 0), w, r);
      end
      step();
    end

    idle();
    out_ready = 1;
    repeat (3) step();
    chk("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
